// File: rtl/foo_pipe_arbiter.sv
// Round-robin front end sharing one foo pipeline among NUM_REQ requesters, with
// credited per-requester response FIFOs. Optional tag check: FOO_PIPE_ARB_TAG_CHECK_EN.

module foo_pipe_arbiter_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  resp_ready_i,
    output logic                  credit_ok_o,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_data_o
);
    localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(RESP_DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(RESP_DEPTH - 1);

    logic [RESP_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d, credit_q, credit_d;
    logic          pop;

    assign resp_valid_o = (cnt_q != '0);
    assign resp_data_o  = resp_valid_o ? mem_q[rd_q] : '0;
    assign credit_ok_o  = (credit_q != '0);
    assign pop          = resp_valid_o & resp_ready_i;

    always_comb begin
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        credit_d = credit_q;
        if (pop)    rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
        if (push_i) wr_d = (wr_q == LAST) ? '0 : wr_q + AW'(1);
        case ({push_i, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
        // Credit tracks free FIFO slots including results still in flight.
        case ({accept_i, pop})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            credit_q <= DEPTH;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            if (push_i) mem_q[wr_q] <= push_data_i;
        end
    end
endmodule

module foo_pipe_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3,
    parameter int RESP_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic                          pipe_valid,
    output logic [DATA_WIDTH-1:0]         pipe_x,
    input  logic [DATA_WIDTH-1:0]         pipe_out,
    input  logic                          pipe_output_valid,
    output logic                          err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a, resp_data_a;
    logic [NUM_REQ-1:0] credit_ok, elig, gnt_oh, push;
    logic               gnt_any;
    logic [IDW-1:0]     gnt_idx, ptr_q, ptr_d, id_q;
    logic               pipe_valid_q;
    logic [DATA_WIDTH-1:0] pipe_x_q;
    logic [LATENCY-1:0]    vld_pipe_q;
    logic [LATENCY-1:0][IDW-1:0] id_pipe_q;
    logic               wr_en;
    logic [IDW-1:0]     wr_id;

    assign req_data_a = req_data;
    assign resp_data  = resp_data_a;
    assign elig       = req_valid & credit_ok;

    // First pass finds eligible indices at/after ptr, second pass covers the wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && elig[i] && (IDW'(i) >= ptr_q)) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && elig[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any && rst) gnt_oh[gnt_idx] = 1'b1;
    end
    assign req_ready = gnt_oh;

    assign ptr_d = !gnt_any ? ptr_q :
                   (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_x_q     <= '0;
            id_q         <= '0;
            vld_pipe_q   <= '0;
            id_pipe_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            pipe_valid_q <= gnt_any;
            if (gnt_any) begin
                pipe_x_q <= req_data_a[gnt_idx];
                id_q     <= gnt_idx;
            end
            vld_pipe_q[0] <= pipe_valid_q;
            id_pipe_q[0]  <= id_q;
            for (int s = 1; s < LATENCY; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                id_pipe_q[s]  <= id_pipe_q[s-1];
            end
        end
    end

    assign pipe_valid = pipe_valid_q;
    assign pipe_x     = pipe_x_q;
    assign wr_en      = vld_pipe_q[LATENCY-1];
    assign wr_id      = id_pipe_q[LATENCY-1];

`ifdef FOO_PIPE_ARB_TAG_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           err_q <= 1'b0;
        else if (pipe_output_valid != wr_en) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    logic unused_out_vld;
    assign unused_out_vld = pipe_output_valid;
    assign err = 1'b0;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign push[i] = wr_en & (wr_id == IDW'(i));
        foo_pipe_arbiter_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .RESP_DEPTH(RESP_DEPTH)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .accept_i     (req_valid[i] & req_ready[i]),
            .push_i       (push[i]),
            .push_data_i  (pipe_out),
            .resp_ready_i (resp_ready[i]),
            .credit_ok_o  (credit_ok[i]),
            .resp_valid_o (resp_valid[i]),
            .resp_data_o  (resp_data_a[i])
        );
    end
endmodule

// File: tb/tb_foo_pipe_arbiter.sv
// Randomized scoreboard bench for foo_pipe_arbiter with a behavioural foo stand-in.
// Honours FOO_PIPE_ARB_TAG_CHECK_EN for the err expectation.

module tb_foo_pipe_arbiter;
    localparam int N = 4, DW = 32, L = 3, D = 2;

    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*DW-1:0] req_data, resp_data;
    logic            pipe_valid, pipe_output_valid, err, force_ov;
    logic [DW-1:0]   pipe_x, pipe_out;

    int errors = 0, checks = 0, cyc = 0, acc1 = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    foo_pipe_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LATENCY(L), .RESP_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(resp_ready), .pipe_valid(pipe_valid), .pipe_x(pipe_x),
        .pipe_out(pipe_out), .pipe_output_valid(pipe_output_valid), .err(err)
    );

    // foo: add 1, then add 1 to the upper 31 bits
    function automatic logic [DW-1:0] foo_fn(input logic [DW-1:0] x);
        logic [DW-1:0] t;
        t = x + 1;
        return {t[DW-1:1] + 1'b1, t[0]};
    endfunction

    logic [L-1:0]         fv_q;
    logic [L-1:0][DW-1:0] fd_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fv_q <= '0;
            fd_q <= '0;
        end else begin
            fv_q <= {fv_q[L-2:0], pipe_valid};
            fd_q <= {fd_q[L-2:0], foo_fn(pipe_x)};
        end
    end
    assign pipe_output_valid = fv_q[L-1] | force_ov;
    assign pipe_out          = fd_q[L-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration, credits, issue register
    typedef struct packed { logic [DW-1:0] data; logic [31:0] arr; } exp_t;
    exp_t exp_q[N][$];
    int   avail_q[N][$];
    int   mptr, g;
    int   mcredit[N];
    logic exp_pv;
    logic [DW-1:0] exp_px;
    logic [N-1:0]  exp_rdy;

    always @(negedge clk) begin
        if (!rst) begin
            mptr = 0; exp_pv = 1'b0; exp_px = '0;
            for (int i = 0; i < N; i++) begin
                mcredit[i] = D;
                avail_q[i].delete();
                exp_q[i].delete();
            end
            check("rst_req_ready", req_ready, 0);
            check("rst_pipe_valid", pipe_valid, 0);
            check("rst_pipe_x", pipe_x, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_err", err, 0);
            for (int i = 0; i < N; i++) check("rst_resp_data", resp_data[i*DW +: DW], 0);
        end else begin
            check("pipe_valid", pipe_valid, exp_pv);
            check("pipe_x", pipe_x, exp_px);
            check("err", err, exp_err);
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(mptr + k) % N] && mcredit[(mptr + k) % N] > 0)
                    g = (mptr + k) % N;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            for (int i = 0; i < N; i++)
                if (avail_q[i].size() > 0 && avail_q[i][0] <= cyc && resp_ready[i]) begin
                    void'(avail_q[i].pop_front());
                    mcredit[i]++;
                end
            exp_pv = (g >= 0);
            if (g >= 0) begin
                mcredit[g]--;
                avail_q[g].push_back(cyc + 2 + L);
                exp_q[g].push_back('{data: foo_fn(req_data[g*DW +: DW]), arr: 32'(cyc + 2 + L)});
                exp_px = req_data[g*DW +: DW];
                mptr = (g + 1) % N;
            end
        end
    end

    // Monitor: compares whatever the response side presents against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (exp_q[i].size() > 0 && exp_q[i][0].arr <= 32'(cyc)) begin
                    check("resp_valid", resp_valid[i], 1);
                    check("resp_data", resp_data[i*DW +: DW], exp_q[i][0].data);
                    if (resp_valid[i] && resp_ready[i]) void'(exp_q[i].pop_front());
                end else begin
                    check("resp_valid_idle", resp_valid[i], 0);
                end
            end
        end
    end

    always @(negedge clk) if (req_valid[1] && req_ready[1]) acc1 <= acc1 + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        exp_err = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    int acc_base;

    initial begin
        req_valid = '0; req_data = '0; resp_ready = '1; force_ov = 1'b0;
        tick(3);
        rst = 1'b1;

        // single request and wrap-around data
        set_req(0, 1'b1, 32'd5); tick(1); req_valid = '0; tick(8);
        set_req(2, 1'b1, 32'hFFFF_FFFF); tick(1); req_valid = '0; tick(8);

        // round-robin with all requesters active
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(16 * c + i));
            tick(1);
        end
        req_valid = '0; tick(10);

        // credit exhaustion on requester 1
        do_reset();
        resp_ready[1] = 1'b0;
        acc_base = acc1;
        for (int c = 0; c < 8; c++) begin
            set_req(1, 1'b1, 32'(200 + c));
            tick(1);
        end
        check("credit_exhaust_accepts", 32'(acc1 - acc_base), 2);
        resp_ready[1] = 1'b1; tick(1); resp_ready[1] = 1'b0;
        @(negedge clk);
        check("credit_regrant", req_ready[1], 1);
        tick(1);
        req_valid = '0; resp_ready = '1; tick(10);
        check("credit_total_accepts", 32'(acc1 - acc_base), 3);

        // reset while requests are in flight
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 32'(300 + i));
        tick(2);
        rst = 1'b0; tick(1); rst = 1'b1;
        req_valid = '0; tick(10);
        set_req(0, 1'b1, 32'd7); tick(1); req_valid = '0; tick(8);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), $urandom);
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick(1);
        end
        req_valid = '0; resp_ready = '1; tick(12);

        // spurious output_valid with no tag in flight
        force_ov = 1'b1; tick(1); force_ov = 1'b0;
`ifdef FOO_PIPE_ARB_TAG_CHECK_EN
        exp_err = 1'b1;
`endif
        tick(10);
        @(negedge clk);
        check("err_after_force", err, exp_err);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
